// File: rtl/beam_trigger_capture_pkg.sv
// beam_capture_pkg: shared types for the beam trigger capture block.
//   state_t     : capture controller states
//   word_t      : one 128-bit packed sample word
//   capture_len : words per captured frame (pre-trigger + post-trigger)
package beam_capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE_FILL,
    ARMED,
    POST,
    READOUT
  } state_t;

  typedef logic [127:0] word_t;

  function automatic int capture_len(input int pre_words, input int post_words);
    return pre_words + post_words;
  endfunction

endpackage

// File: rtl/beam_trigger_capture_if.sv
// beam_trigger_capture_if: AXI4-Stream link carrying captured frames.
//   tdata  : captured 128-bit word
//   tvalid : word valid
//   tready : sink ready
//   tlast  : last word of the frame
//   tuser  : beams that fired, latched at the trigger
// master = capture block side, slave = buffer/DMA side.
interface beam_trigger_capture_if #(
  parameter int NBEAMS = 2
);
  import beam_capture_pkg::*;

  word_t             tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [NBEAMS-1:0] tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);

endinterface

// File: rtl/beam_trigger_capture_sdp_ram.sv
// capture_sdp_ram: simple dual-port RAM, one write port and one read port
// with a registered (1-cycle latency) read, written to map onto block RAM.
//   clk     : clock
//   wr_en   : write strobe, wr_addr/wr_data : write address/data
//   rd_en   : read strobe,  rd_addr         : read address
//   rd_data : data for the address presented on the previous rd_en cycle
module capture_sdp_ram #(
  parameter int WIDTH      = 128,
  parameter int DEPTH_BITS = 9
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [2**DEPTH_BITS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/beam_trigger_capture.sv
// beam_trigger_capture: keeps a circular history of the filtered sample
// stream; once armed and pre-filled, an unmasked beam trigger freezes a
// PRE_WORDS + POST_WORDS window which is then streamed out over AXI4-Stream.
//   aclk, reset_i      : clock, synchronous active-high reset
//   dat_tdata/tvalid   : input sample words (no backpressure)
//   trig_i/beam_mask_i : per-beam trigger level / ignore mask
//   arm_i              : single-cycle arm request (honoured in IDLE only)
//   m                  : AXI4-Stream master carrying the captured frame
//   busy_o             : controller not idle
//   trig_count_o       : accepted triggers (saturating)
//   miss_count_o       : trigger cycles seen while unable to accept (saturating)
module beam_trigger_capture
  import beam_capture_pkg::*;
#(
  parameter int NBEAMS     = 2,
  parameter int DEPTH_BITS = 9,
  parameter int PRE_WORDS  = 32,
  parameter int POST_WORDS = 96
) (
  input  logic                  aclk,
  input  logic                  reset_i,
  input  word_t                 dat_tdata,
  input  logic                  dat_tvalid,
  input  logic [NBEAMS-1:0]     trig_i,
  input  logic [NBEAMS-1:0]     beam_mask_i,
  input  logic                  arm_i,
  beam_trigger_capture_if.master m,
  output logic                  busy_o,
  output logic [31:0]           trig_count_o,
  output logic [15:0]           miss_count_o
);

  localparam int CNT_W = DEPTH_BITS + 1;
  localparam logic [CNT_W-1:0]      ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0]      LEN_C   = CNT_W'(capture_len(PRE_WORDS, POST_WORDS));
  localparam logic [CNT_W-1:0]      PRE_C   = CNT_W'(PRE_WORDS);
  localparam logic [CNT_W-1:0]      POST_C  = CNT_W'(POST_WORDS);
  localparam logic [DEPTH_BITS-1:0] PRE_OFS = DEPTH_BITS'(PRE_WORDS);
  localparam logic [DEPTH_BITS-1:0] ADDR_1  = DEPTH_BITS'(1);

  state_t                state_reg;
  logic [DEPTH_BITS-1:0] wr_ptr_reg;
  logic [DEPTH_BITS-1:0] rd_ptr_reg;
  logic [CNT_W-1:0]      prefill_reg;
  logic [CNT_W-1:0]      post_reg;
  logic [CNT_W-1:0]      issue_left_reg;
  logic [NBEAMS-1:0]     tuser_reg;
  logic [31:0]           trig_count_reg;
  logic [15:0]           miss_count_reg;

  // Two-entry output buffer fed by the RAM; entry 0 drives the bus.
  logic [1:0] cnt_reg;
  logic       inflight_reg;
  logic       inflight_last_reg;
  word_t      e0_data_reg, e1_data_reg;
  logic       e0_last_reg, e1_last_reg;

  word_t             rd_data;
  logic [NBEAMS-1:0] hit_vec;
  logic              hit, wr_en, pop, push, issue, miss_evt;

  assign hit_vec  = trig_i & ~beam_mask_i;
  assign hit      = |hit_vec;
  assign wr_en    = dat_tvalid && (state_reg != READOUT);
  assign pop      = (cnt_reg != 2'd0) && m.tready;
  assign push     = inflight_reg;
  // Issue a read only when the word is guaranteed a buffer slot on arrival,
  // counting the word already in flight and the slot freed by this cycle's pop.
  assign issue    = (state_reg == READOUT) && (issue_left_reg != '0) &&
                    (({1'b0, cnt_reg} + {2'b00, inflight_reg}) < (3'd2 + {2'b00, pop}));
  assign miss_evt = hit && ((state_reg == PRE_FILL) || (state_reg == POST) ||
                            (state_reg == READOUT));

  capture_sdp_ram #(
    .WIDTH     (128),
    .DEPTH_BITS(DEPTH_BITS)
  ) u_ram (
    .clk    (aclk),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr_reg),
    .wr_data(dat_tdata),
    .rd_en  (issue),
    .rd_addr(rd_ptr_reg),
    .rd_data(rd_data)
  );

  always_ff @(posedge aclk) begin
    if (reset_i) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      prefill_reg    <= '0;
      post_reg       <= '0;
      issue_left_reg <= '0;
      tuser_reg      <= '0;
      trig_count_reg <= '0;
      miss_count_reg <= '0;
      cnt_reg        <= '0;
      inflight_reg   <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_1;
      end
      if (miss_evt && (miss_count_reg != '1)) begin
        miss_count_reg <= miss_count_reg + 16'd1;
      end

      case (state_reg)
        IDLE: begin
          if (arm_i) begin
            prefill_reg <= '0;
            state_reg   <= PRE_FILL;
          end
        end
        PRE_FILL: begin
          if (dat_tvalid) begin
            prefill_reg <= prefill_reg + ONE_C;
            if ((prefill_reg + ONE_C) == PRE_C) begin
              state_reg <= ARMED;
            end
          end
        end
        ARMED: begin
          if (hit && dat_tvalid) begin
            tuser_reg      <= hit_vec;
            rd_ptr_reg     <= wr_ptr_reg - PRE_OFS;
            issue_left_reg <= LEN_C;
            post_reg       <= ONE_C;
            if (trig_count_reg != '1) begin
              trig_count_reg <= trig_count_reg + 32'd1;
            end
            state_reg <= (POST_C == ONE_C) ? READOUT : POST;
          end
        end
        POST: begin
          if (dat_tvalid) begin
            post_reg <= post_reg + ONE_C;
            if ((post_reg + ONE_C) == POST_C) begin
              state_reg <= READOUT;
            end
          end
        end
        READOUT: begin
          if (pop && e0_last_reg) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase

      inflight_reg <= issue;
      if (issue) begin
        rd_ptr_reg     <= rd_ptr_reg + ADDR_1;
        issue_left_reg <= issue_left_reg - ONE_C;
      end

      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + 2'd1;
        2'b01:   cnt_reg <= cnt_reg - 2'd1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  // Buffer payload needs no reset: it is only visible while cnt_reg != 0.
  always_ff @(posedge aclk) begin
    if (issue) begin
      inflight_last_reg <= (issue_left_reg == ONE_C);
    end
    case ({push, pop})
      2'b10: begin
        if (cnt_reg == 2'd0) begin
          e0_data_reg <= rd_data;
          e0_last_reg <= inflight_last_reg;
        end else begin
          e1_data_reg <= rd_data;
          e1_last_reg <= inflight_last_reg;
        end
      end
      2'b01: begin
        e0_data_reg <= e1_data_reg;
        e0_last_reg <= e1_last_reg;
      end
      2'b11: begin
        if (cnt_reg == 2'd1) begin
          e0_data_reg <= rd_data;
          e0_last_reg <= inflight_last_reg;
        end else begin
          e0_data_reg <= e1_data_reg;
          e0_last_reg <= e1_last_reg;
          e1_data_reg <= rd_data;
          e1_last_reg <= inflight_last_reg;
        end
      end
      default: ;
    endcase
  end

  assign m.tdata      = e0_data_reg;
  assign m.tvalid     = (cnt_reg != 2'd0);
  assign m.tlast      = e0_last_reg && (cnt_reg != 2'd0);
  assign m.tuser      = tuser_reg;
  assign busy_o       = (state_reg != IDLE);
  assign trig_count_o = trig_count_reg;
  assign miss_count_o = miss_count_reg;

endmodule

// File: tb/tb_beam_trigger_capture.sv
// tb_beam_trigger_capture: directed bench for beam_trigger_capture with a
// 16-word RAM, 4 pre-trigger and 8 post-trigger words. Input word n carries
// the value n, so every captured frame must be a run of consecutive values.
module tb_beam_trigger_capture;
  import beam_capture_pkg::*;

  localparam int NB   = 2;
  localparam int DB   = 4;
  localparam int PRE  = 4;
  localparam int POST = 8;
  localparam int LEN  = PRE + POST;

  logic          aclk = 1'b0;
  logic          reset_i;
  word_t         dat_tdata;
  logic          dat_tvalid;
  logic [NB-1:0] trig_i;
  logic [NB-1:0] beam_mask_i;
  logic          arm_i;
  logic          busy_o;
  logic [31:0]   trig_count_o;
  logic [15:0]   miss_count_o;

  beam_trigger_capture_if #(.NBEAMS(NB)) m_if ();

  beam_trigger_capture #(
    .NBEAMS    (NB),
    .DEPTH_BITS(DB),
    .PRE_WORDS (PRE),
    .POST_WORDS(POST)
  ) dut (
    .aclk        (aclk),
    .reset_i     (reset_i),
    .dat_tdata   (dat_tdata),
    .dat_tvalid  (dat_tvalid),
    .trig_i      (trig_i),
    .beam_mask_i (beam_mask_i),
    .arm_i       (arm_i),
    .m           (m_if.master),
    .busy_o      (busy_o),
    .trig_count_o(trig_count_o),
    .miss_count_o(miss_count_o)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [NB-1:0] mask_a;
    logic [NB-1:0] trig_a;
    bit            a_hits;
    logic [NB-1:0] mask_b;
    logic [NB-1:0] trig_b;
    logic [NB-1:0] exp_user;
  } vec_t;

  int          n_checks;
  int          n_fail;
  int unsigned word_n;
  word_t         got_d[$];
  logic          got_l[$];
  logic [NB-1:0] got_u[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge aclk);
    if (dat_tvalid) word_n++;
    #1;
    dat_tdata = word_t'(word_n);
  endtask

  task automatic do_reset();
    reset_i = 1'b1; arm_i = 1'b0; trig_i = '0; beam_mask_i = '0;
    m_if.tready = 1'b0; dat_tvalid = 1'b1;
    tick(); tick();
    reset_i = 1'b0; word_n = 0; dat_tdata = '0;
  endtask

  task automatic arm_wait();
    arm_i = 1'b1; tick(); arm_i = 1'b0;
    repeat (PRE) tick();
  endtask

  task automatic collect_frame(input bit rnd, input int max_words, output int n);
    bit    held_v, done;
    word_t held_d;
    logic  held_l;
    n = 0; done = 1'b0; held_v = 1'b0; held_d = '0; held_l = 1'b0;
    got_d.delete(); got_l.delete(); got_u.delete();
    for (int c = 0; c < 300 && !done && n < max_words; c++) begin
      m_if.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held_v) begin
        chk("stall_valid", 128'(m_if.tvalid), 128'(1));
        chk("stall_data", m_if.tdata, held_d);
        chk("stall_last", 128'(m_if.tlast), 128'(held_l));
      end
      held_v = m_if.tvalid && !m_if.tready;
      held_d = m_if.tdata;
      held_l = m_if.tlast;
      if (m_if.tvalid && m_if.tready) begin
        got_d.push_back(m_if.tdata);
        got_l.push_back(m_if.tlast);
        got_u.push_back(m_if.tuser);
        n++;
        if (m_if.tlast) done = 1'b1;
      end
      tick();
    end
    m_if.tready = 1'b0;
    if (!done && n < max_words) begin
      n_checks++; n_fail++;
      $display("FAIL frame_timeout: got %0d words, required %0d", n, max_words);
    end
  endtask

  task automatic check_frame(input int unsigned first, input logic [NB-1:0] user, input int n);
    chk("frame_len", 128'(n), 128'(LEN));
    for (int i = 0; i < got_d.size(); i++) begin
      chk($sformatf("word%0d_data", i), got_d[i], word_t'(first + i));
      chk($sformatf("word%0d_last", i), 128'(got_l[i]), 128'(i == LEN - 1));
    end
    if (got_u.size() > 0) chk("tuser", 128'(got_u[0]), 128'(user));
    chk("idle_after_frame", 128'(busy_o), 128'(0));
    $display("frame first=%0d words=%0d tuser=%b", first, n, user);
  endtask

  task automatic wait_valid(output int lat);
    for (lat = 0; lat < 30 && !m_if.tvalid; lat++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[6];
    int          n, lat;
    int unsigned tw, exp_trig;

    vecs[0] = '{mask_a: 2'b00, trig_a: 2'b01, a_hits: 1'b1, mask_b: 2'b00, trig_b: 2'b00, exp_user: 2'b01};
    vecs[1] = '{mask_a: 2'b01, trig_a: 2'b01, a_hits: 1'b0, mask_b: 2'b01, trig_b: 2'b10, exp_user: 2'b10};
    vecs[2] = '{mask_a: 2'b10, trig_a: 2'b11, a_hits: 1'b1, mask_b: 2'b00, trig_b: 2'b00, exp_user: 2'b01};
    vecs[3] = '{mask_a: 2'b11, trig_a: 2'b11, a_hits: 1'b0, mask_b: 2'b00, trig_b: 2'b10, exp_user: 2'b10};
    vecs[4] = '{mask_a: 2'b00, trig_a: 2'b11, a_hits: 1'b1, mask_b: 2'b00, trig_b: 2'b00, exp_user: 2'b11};
    vecs[5] = '{mask_a: 2'b01, trig_a: 2'b11, a_hits: 1'b1, mask_b: 2'b00, trig_b: 2'b00, exp_user: 2'b10};

    n_checks = 0; n_fail = 0; word_n = 0;
    dat_tdata = '0; dat_tvalid = 1'b1; trig_i = '0; beam_mask_i = '0; arm_i = 1'b0;
    reset_i = 1'b1; m_if.tready = 1'b0;

    // Reset state
    do_reset();
    chk("rst_tvalid", 128'(m_if.tvalid), 128'(0));
    chk("rst_tlast", 128'(m_if.tlast), 128'(0));
    chk("rst_tuser", 128'(m_if.tuser), 128'(0));
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_trig_count", 128'(trig_count_o), 128'(0));
    chk("rst_miss_count", 128'(miss_count_o), 128'(0));

    // Basic capture: arm at word 0, trigger at word 20
    arm_i = 1'b1; tick(); arm_i = 1'b0;
    chk("busy_after_arm", 128'(busy_o), 128'(1));
    while (word_n != 20) tick();
    trig_i = 2'b01; tick(); trig_i = '0;
    chk("basic_trig_count", 128'(trig_count_o), 128'(1));
    wait_valid(lat);
    n_checks++;
    if (lat < POST || lat > POST + 2) begin
      n_fail++;
      $display("FAIL first_valid_latency: got %0d cycles after trigger, required %0d..%0d", lat, POST, POST + 2);
    end
    collect_frame(1'b0, LEN, n);
    check_frame(16, 2'b01, n);

    // Wrap and random backpressure: T = 33 -> addresses 13..15,0..8
    do_reset();
    arm_i = 1'b1; tick(); arm_i = 1'b0;
    while (word_n != 33) tick();
    trig_i = 2'b01; tick(); trig_i = '0;
    collect_frame(1'b1, LEN, n);
    check_frame(29, 2'b01, n);

    // Mask / tuser table
    do_reset();
    exp_trig = 0;
    for (int v = 0; v < 6; v++) begin
      arm_wait();
      beam_mask_i = vecs[v].mask_a; trig_i = vecs[v].trig_a; tw = word_n;
      tick(); trig_i = '0;
      chk($sformatf("vec%0d_a_accept", v), 128'(trig_count_o), 128'(exp_trig + 32'(vecs[v].a_hits)));
      if (!vecs[v].a_hits) begin
        beam_mask_i = vecs[v].mask_b; trig_i = vecs[v].trig_b; tw = word_n;
        tick(); trig_i = '0;
      end
      exp_trig++;
      beam_mask_i = '0;
      chk($sformatf("vec%0d_trig_count", v), 128'(trig_count_o), 128'(exp_trig));
      collect_frame(1'b0, LEN, n);
      check_frame(tw - PRE, vecs[v].exp_user, n);
      chk($sformatf("vec%0d_miss_count", v), 128'(miss_count_o), 128'(0));
    end

    // Misses during READOUT: trig 11 with mask 01 held for 3 cycles
    do_reset();
    beam_mask_i = 2'b01;
    arm_wait();
    trig_i = 2'b10; tw = word_n; tick(); trig_i = '0;
    wait_valid(lat);
    chk("readout_reached", 128'(m_if.tvalid), 128'(1));
    trig_i = 2'b11; repeat (3) tick(); trig_i = '0; tick();
    chk("readout_miss_count", 128'(miss_count_o), 128'(3));
    collect_frame(1'b0, LEN, n);
    check_frame(tw - PRE, 2'b10, n);
    beam_mask_i = '0;

    // Prefill gate: hits on words 2 and 4 are misses, word 5 is captured
    do_reset();
    arm_i = 1'b1; tick(); arm_i = 1'b0;
    tick();
    trig_i = 2'b01; tick(); trig_i = '0;
    chk("prefill_miss1", 128'(miss_count_o), 128'(1));
    chk("prefill_no_trig1", 128'(trig_count_o), 128'(0));
    tick();
    trig_i = 2'b01; tick(); trig_i = '0;
    chk("prefill_miss2", 128'(miss_count_o), 128'(2));
    chk("prefill_no_trig2", 128'(trig_count_o), 128'(0));
    trig_i = 2'b01; tick(); trig_i = '0;
    chk("prefill_trig", 128'(trig_count_o), 128'(1));
    collect_frame(1'b0, LEN, n);
    check_frame(1, 2'b01, n);

    // Reset after 5 output handshakes, then a clean frame
    do_reset();
    arm_wait();
    trig_i = 2'b01; tw = word_n; tick(); trig_i = '0;
    collect_frame(1'b0, 5, n);
    chk("pre_reset_words", 128'(n), 128'(5));
    if (got_d.size() == 5) chk("pre_reset_word4", got_d[4], word_t'(tw));
    reset_i = 1'b1; m_if.tready = 1'b0; tick();
    chk("midrst_tvalid", 128'(m_if.tvalid), 128'(0));
    chk("midrst_tlast", 128'(m_if.tlast), 128'(0));
    chk("midrst_busy", 128'(busy_o), 128'(0));
    chk("midrst_trig_count", 128'(trig_count_o), 128'(0));
    chk("midrst_miss_count", 128'(miss_count_o), 128'(0));
    reset_i = 1'b0; word_n = 0; dat_tdata = '0;
    arm_wait();
    trig_i = 2'b01; tw = word_n; tick(); trig_i = '0;
    collect_frame(1'b0, LEN, n);
    check_frame(tw - PRE, 2'b01, n);

    // Input gaps: hit without tvalid is not accepted; gaps during POST
    do_reset();
    arm_wait();
    while (word_n != 8) tick();
    dat_tvalid = 1'b0; trig_i = 2'b01; tick(); trig_i = '0;
    chk("gap_no_accept", 128'(trig_count_o), 128'(0));
    chk("gap_no_miss", 128'(miss_count_o), 128'(0));
    dat_tvalid = 1'b1; trig_i = 2'b01; tw = word_n; tick(); trig_i = '0;
    chk("gap_accept", 128'(trig_count_o), 128'(1));
    for (int k = 0; k < 16; k++) begin
      dat_tvalid = k[0];
      tick();
    end
    dat_tvalid = 1'b1;
    collect_frame(1'b0, LEN, n);
    check_frame(tw - PRE, 2'b01, n);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
